dsm_modulator_2nd: RTL

DSM_MODULATOR_2ND -- requirements
Module: dsm_modulator_2nd

---
 rtl/dsm_modulator_2nd_if.sv | 15 +
 rtl/dsm_modulator_2nd.sv | 105 ++++++++++
 2 files changed

// File: rtl/dsm_modulator_2nd_if.sv
// PCM-in / DSD-out bus of the second-order delta-sigma modulator.
interface dsm_modulator_2nd_if #(
  parameter int PCM_Bit_Length = 32
) ();
  logic signed [PCM_Bit_Length-1:0] PCM_DATA_I;
  logic                             PCM_VALID_I;
  logic                             QUANT_DATA_O;
  logic                             QUANT_VALID_O;
  logic                             OVERLOAD_O;

  modport master (output PCM_DATA_I, PCM_VALID_I,
                  input  QUANT_DATA_O, QUANT_VALID_O, OVERLOAD_O);
  modport slave  (input  PCM_DATA_I, PCM_VALID_I,
                  output QUANT_DATA_O, QUANT_VALID_O, OVERLOAD_O);
endinterface

// File: rtl/dsm_modulator_2nd.sv
// Second-order 1-bit delta-sigma modulator with zero-order-hold input,
// saturating integrators and overload recovery.
module dsm_modulator_2nd #(
  parameter int PCM_Bit_Length = 32,
  parameter int INT_WIDTH      = 40,
  parameter int RECOVER_LIMIT  = 256
) (
  input  logic             BCLK_I,
  input  logic             RESET_I,
  dsm_modulator_2nd_if.slave bus
);
  localparam int SW = INT_WIDTH + 2;
  localparam int CW = $clog2(RECOVER_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(RECOVER_LIMIT);
  localparam logic signed [SW-1:0] MAXV = {3'b000, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {3'b111, {(INT_WIDTH-1){1'b0}}};
  localparam logic signed [PCM_Bit_Length-1:0] FBP = {1'b0, {(PCM_Bit_Length-1){1'b1}}};
  localparam logic signed [PCM_Bit_Length-1:0] FBN = {1'b1, {(PCM_Bit_Length-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;

  state_t                           state, state_nxt;
  logic signed [PCM_Bit_Length-1:0] x_hold;
  logic signed [INT_WIDTH-1:0]      int1, int2, int1_nxt, int2_nxt;
  logic [CW-1:0]                    cnt, cnt_nxt;
  logic signed [SW-1:0]             xs, fb, sum1, sum2;
  logic                             q, ovf;
  logic                             qd, qv, ov;

  function automatic logic signed [INT_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    c = (v > MAXV) ? MAXV : (v < MINV) ? MINV : v;
    return c[INT_WIDTH-1:0];
  endfunction

  // Both integrators share one decision q taken from the current INT2.
  always_comb begin
    xs       = SW'(x_hold >>> 1);
    q        = ~int2[INT_WIDTH-1];
    fb       = q ? SW'(FBP) : SW'(FBN);
    sum1     = SW'(int1) + xs - fb;
    int1_nxt = sat(sum1);
    sum2     = SW'(int2) + SW'(int1_nxt) - fb;
    int2_nxt = sat(sum2);
    ovf      = (sum1 > MAXV) || (sum1 < MINV) || (sum2 > MAXV) || (sum2 < MINV);
    cnt_nxt  = '0;
    if (ovf) cnt_nxt = (cnt == LIM) ? cnt : cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.PCM_VALID_I) state_nxt = RUN;
      RUN:     if (cnt_nxt == LIM) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge BCLK_I) begin
    if (RESET_I) begin
      state  <= IDLE;
      x_hold <= '0;
      int1   <= '0;
      int2   <= '0;
      cnt    <= '0;
      qd     <= 1'b0;
      qv     <= 1'b0;
      ov     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.PCM_VALID_I) x_hold <= bus.PCM_DATA_I;
      case (state)
        IDLE: begin
          int1 <= '0;
          int2 <= '0;
          cnt  <= '0;
          qd   <= ~qd;
          qv   <= 1'b0;
          ov   <= 1'b0;
        end
        RUN: begin
          int1 <= int1_nxt;
          int2 <= int2_nxt;
          cnt  <= cnt_nxt;
          qd   <= q;
          qv   <= 1'b1;
          ov   <= ovf;
        end
        default: begin
          int1 <= '0;
          int2 <= '0;
          cnt  <= '0;
          qd   <= 1'b0;
          qv   <= 1'b0;
          ov   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.QUANT_DATA_O  = qd;
  assign bus.QUANT_VALID_O = qv;
  assign bus.OVERLOAD_O    = ov;
endmodule
